// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: MM:SS stopwatch that outputs four BCD digits.
//   - Three asynchronous push buttons (start/stop, clear, lap). Each one goes
//     through a 2-FF synchroniser and a registered rising-edge detector.
//   - An IDLE/RUN/PAUSE FSM gates a prescaler. The prescaler makes a 1-cycle
//     tick every TICK_DIV clocks while the FSM is in RUN.
//   - The tick advances a cascaded BCD counter that wraps 59:59 -> 00:00.
//   - Lap freezes the displayed digits while the live count keeps running.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   btn_start/clear/lap: pre-debounced button levels, asynchronous to clk
//   digit_mt/mo/st/so  : registered BCD digits (minutes tens/ones, seconds tens/ones)
//   running            : high while in RUN
//   lap_active         : high while the displayed digits are frozen
//   rollover           : 1-cycle pulse coinciding with the 59:59 -> 00:00 wrap
module stopwatch_bcd #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic [3:0] digit_mt,
  output logic [3:0] digit_mo,
  output logic [3:0] digit_st,
  output logic [3:0] digit_so,
  output logic       running,
  output logic       lap_active,
  output logic       rollover
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  // Button vector bits: [0] start, [1] clear, [2] lap
  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, edge_q, edge_d;
  state_t           state_q, state_d;
  logic             lap_q, lap_d, run_q, run_d, roll_q, roll_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [15:0]      live_q, live_d, disp_q, disp_d, dig_q, dig_d;  // {mt, mo, st, so}
  logic             start_e, clear_e, lap_e, tick, clr_cnt;
  logic [3:0]       mt_n, mo_n, st_n, so_n;

  assign start_e = edge_q[0];
  assign clear_e = edge_q[1];
  assign lap_e   = edge_q[2];

  // Synchroniser and edge-detector next state. The edge pulse is registered,
  // so it appears on the third clock edge after the button rises.
  always_comb begin
    sync1_d = {btn_lap, btn_clear, btn_start};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    edge_d  = sync2_q & ~prev_q;
  end

  // FSM next state. Priority within one cycle is clear > start > lap.
  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    clr_cnt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear_e) begin
          clr_cnt = 1'b1;
        end else if (start_e) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Clear is deliberately ignored while running.
        if (start_e) begin
          state_d = S_PAUSE;
        end else if (lap_e) begin
          lap_d = ~lap_q;
        end else begin
          lap_d = lap_q;
        end
      end
      S_PAUSE: begin
        if (clear_e) begin
          state_d = S_IDLE;
          lap_d   = 1'b0;
          clr_cnt = 1'b1;
        end else if (start_e) begin
          state_d = S_RUN;
        end else if (lap_e && lap_q) begin
          lap_d = 1'b0;
        end else begin
          lap_d = lap_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        lap_d   = 1'b0;
      end
    endcase
    run_d = (state_d == S_RUN);
  end

  // Prescaler. It holds in PAUSE so a resumed second keeps its elapsed fraction.
  always_comb begin
    tick    = (state_q == S_RUN) && (presc_q == CNT_W'(TICK_DIV - 1));
    presc_d = presc_q;
    if (clr_cnt) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end else if (state_q == S_RUN) begin
      presc_d = presc_q + CNT_W'(1);
    end else begin
      presc_d = presc_q;
    end
  end

  // Cascaded BCD increment of the live count.
  always_comb begin
    {mt_n, mo_n, st_n, so_n} = live_q;
    roll_d = 1'b0;
    if (live_q[3:0] == 4'd9) begin
      so_n = 4'd0;
      if (live_q[7:4] == 4'd5) begin
        st_n = 4'd0;
        if (live_q[11:8] == 4'd9) begin
          mo_n = 4'd0;
          if (live_q[15:12] == 4'd5) begin
            mt_n   = 4'd0;
            roll_d = tick;
          end else begin
            mt_n = live_q[15:12] + 4'd1;
          end
        end else begin
          mo_n = live_q[11:8] + 4'd1;
        end
      end else begin
        st_n = live_q[7:4] + 4'd1;
      end
    end else begin
      so_n = live_q[3:0] + 4'd1;
    end

    if (clr_cnt) begin
      live_d = 16'h0000;
    end else if (tick) begin
      live_d = {mt_n, mo_n, st_n, so_n};
    end else begin
      live_d = live_q;
    end
  end

  // Lap display register and output mux. The display register captures the
  // pre-tick live count on the cycle lap_active rises.
  always_comb begin
    if (clr_cnt) begin
      disp_d = 16'h0000;
    end else if (lap_d && !lap_q) begin
      disp_d = live_q;
    end else begin
      disp_d = disp_q;
    end
    dig_d = lap_d ? disp_d : live_d;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      prev_q  <= 3'b000;
      edge_q  <= 3'b000;
      state_q <= S_IDLE;
      lap_q   <= 1'b0;
      run_q   <= 1'b0;
      roll_q  <= 1'b0;
      presc_q <= '0;
      live_q  <= 16'h0000;
      disp_q  <= 16'h0000;
      dig_q   <= 16'h0000;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      edge_q  <= edge_d;
      state_q <= state_d;
      lap_q   <= lap_d;
      run_q   <= run_d;
      roll_q  <= roll_d;
      presc_q <= presc_d;
      live_q  <= live_d;
      disp_q  <= disp_d;
      dig_q   <= dig_d;
    end
  end

  assign {digit_mt, digit_mo, digit_st, digit_so} = dig_q;
  assign running    = run_q;
  assign lap_active = lap_q;
  assign rollover   = roll_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench for stopwatch_bcd with TICK_DIV = 4.
// Inputs change and outputs are sampled on the falling clock edge.
// Each press holds a button for four rising edges, and the FSM acts on the
// fourth of those edges.
module tb_stopwatch_bcd;

  logic       clk, rst, btn_start, btn_clear, btn_lap;
  logic [3:0] digit_mt, digit_mo, digit_st, digit_so;
  logic       running, lap_active, rollover;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         adv;
    logic [3:0] mt, mo, st, so;
    logic       run, lap, roll;
  } vec_t;

  vec_t tbl[14];

  stopwatch_bcd #(.TICK_DIV(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .btn_start(btn_start), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .digit_mt(digit_mt), .digit_mo(digit_mo), .digit_st(digit_st), .digit_so(digit_so),
    .running(running), .lap_active(lap_active), .rollover(rollover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic [15:0] dig,
                           input logic run, input logic lap);
    chk({name, ".digits"}, {digit_mt, digit_mo, digit_st, digit_so}, dig);
    chk({name, ".running"}, {15'd0, running}, {15'd0, run});
    chk({name, ".lap"}, {15'd0, lap_active}, {15'd0, lap});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 start, 1 clear, 2 lap
  task automatic press(input int which);
    if (which == 0) btn_start = 1'b1;
    else if (which == 1) btn_clear = 1'b1;
    else btn_lap = 1'b1;
    cyc(4);
    btn_start = 1'b0;
    btn_clear = 1'b0;
    btn_lap   = 1'b0;
  endtask

  initial begin
    // Edge counts are measured from the edge on which RUN was entered (TICK_DIV=4).
    tbl[0]  = '{36,    4'd0, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{3,     4'd0, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1,     4'd0, 4'd0, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{120,   4'd0, 4'd0, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{76,    4'd0, 4'd0, 4'd5, 4'd9, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{3,     4'd0, 4'd0, 4'd5, 4'd9, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1,     4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{2160,  4'd1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{11992, 4'd5, 4'd9, 4'd5, 4'd8, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{3,     4'd5, 4'd9, 4'd5, 4'd8, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1,     4'd5, 4'd9, 4'd5, 4'd9, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{3,     4'd5, 4'd9, 4'd5, 4'd9, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1,     4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1,     4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    btn_lap   = 1'b0;
    #1;
    chk_state("reset", 16'h0000, 1'b0, 1'b0);
    chk("reset.rollover", {15'd0, rollover}, 16'd0);
    cyc(3);
    rst = 1'b0;

    // Idle with no buttons pressed.
    cyc(100);
    chk_state("idle100", 16'h0000, 1'b0, 1'b0);

    // Pause keeps the elapsed fraction of a second. The first tick also shows
    // that the prescaler stayed at 0 through the idle period.
    press(0);
    chk_state("start", 16'h0000, 1'b1, 1'b0);
    cyc(2);
    press(0);                                   // 6 RUN edges: 00:01, prescaler at 2
    chk_state("pause", 16'h0001, 1'b0, 1'b0);
    cyc(50);
    chk_state("pause_hold", 16'h0001, 1'b0, 1'b0);
    press(0);
    chk_state("resume", 16'h0001, 1'b1, 1'b0);
    cyc(1);
    chk_state("resume+1", 16'h0001, 1'b1, 1'b0);
    cyc(1);
    chk_state("resume+2", 16'h0002, 1'b1, 1'b0);
    press(0);
    chk_state("pause2", 16'h0003, 1'b0, 1'b0);
    press(1);
    chk_state("clear_pause", 16'h0000, 1'b0, 1'b0);

    // Counting, carries and rollover, driven from the vector table.
    press(0);
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].adv);
      chk_state($sformatf("tbl%0d", i), {tbl[i].mt, tbl[i].mo, tbl[i].st, tbl[i].so},
                tbl[i].run, tbl[i].lap);
      chk($sformatf("tbl%0d.rollover", i), {15'd0, rollover}, {15'd0, tbl[i].roll});
    end

    // Clear is ignored while running.
    press(1);
    chk_state("clear_in_run", 16'h0001, 1'b1, 1'b0);

    // Lap freezes the display while the live count keeps running.
    cyc(12);
    chk_state("pre_lap", 16'h0004, 1'b1, 1'b0);
    press(2);
    chk_state("lap_on", 16'h0005, 1'b1, 1'b1);
    cyc(14);
    chk_state("lap_frozen", 16'h0005, 1'b1, 1'b1);
    press(2);
    chk_state("lap_off", 16'h0009, 1'b1, 1'b0);

    // A lap press in PAUSE with lap inactive is ignored. Clear and start together
    // in PAUSE go to IDLE, and the start is dropped.
    press(0);
    chk_state("pause3", 16'h0010, 1'b0, 1'b0);
    press(2);
    chk_state("lap_in_pause", 16'h0010, 1'b0, 1'b0);
    btn_start = 1'b1;
    press(1);
    chk_state("clear_start", 16'h0000, 1'b0, 1'b0);
    cyc(8);
    chk_state("clear_start_hold", 16'h0000, 1'b0, 1'b0);

    // The prescaler was zeroed by clear, so a full second is needed for the first tick.
    press(0);
    cyc(3);
    chk_state("fresh+3", 16'h0000, 1'b1, 1'b0);
    cyc(1);
    chk_state("fresh+4", 16'h0001, 1'b1, 1'b0);
    press(2);
    chk_state("lap_before_rst", 16'h0001, 1'b1, 1'b1);

    // Reset mid-run takes effect with no clock edge.
    cyc(2);
    rst = 1'b1;
    #1;
    chk_state("async_rst", 16'h0000, 1'b0, 1'b0);
    chk("async_rst.rollover", {15'd0, rollover}, 16'd0);
    cyc(2);
    rst = 1'b0;
    cyc(10);
    chk_state("post_rst", 16'h0000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
